// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit for the decode stage: four extension modes, registered output behind valid/ready.
// Build option IMM_EXT_SKID_EN selects a 2-entry skid buffer with registered in_ready; default is a single stage.
module imm_extend_pipe #(
  parameter int IN_W    = 26,
  parameter int OUT_W   = 32,  // must cover IN_W + SHIFT and 2*SHORT_W
  parameter int SHORT_W = 16,
  parameter int SHIFT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [OUT_W-1:0] ext_short_s;
  logic [OUT_W-1:0] ext_short_z;
  logic [OUT_W-1:0] ext_full_s;
  logic [OUT_W-1:0] ext_branch;
  logic [OUT_W-1:0] ext_upper;
  logic [OUT_W-1:0] ext_data;

  assign ext_short_s = {{(OUT_W-SHORT_W){in_data[SHORT_W-1]}}, in_data[SHORT_W-1:0]};
  assign ext_short_z = {{(OUT_W-SHORT_W){1'b0}}, in_data[SHORT_W-1:0]};
  assign ext_full_s  = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign ext_branch  = ext_full_s << SHIFT;
  assign ext_upper   = {in_data[SHORT_W-1:0], {(OUT_W-SHORT_W){1'b0}}};

  always_comb begin
    ext_data = ext_short_s;
    case (in_mode)
      2'd0:    ext_data = ext_short_s;
      2'd1:    ext_data = ext_short_z;
      2'd2:    ext_data = ext_branch;
      2'd3:    ext_data = ext_upper;
      default: ext_data = ext_short_s;
    endcase
  end

  state_t           state_q, state_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [1:0]       head_mode_q, head_mode_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid_q && out_ready;

`ifdef IMM_EXT_SKID_EN
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]       skid_mode_q, skid_mode_d;
  logic             in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_mode_d = head_mode_q;
    skid_data_d = skid_data_q;
    skid_mode_d = skid_mode_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_data_d = ext_data;
          head_mode_d = in_mode;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          head_data_d = ext_data;
          head_mode_d = in_mode;
        end else if (accept) begin
          skid_data_d = ext_data;
          skid_mode_d = in_mode;
          state_d     = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          head_data_d = skid_data_q;
          head_mode_d = skid_mode_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q <= '0;
      skid_mode_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_data_q <= skid_data_d;
      skid_mode_q <= skid_mode_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  // Single stage: a stalled head can still be replaced in the cycle it leaves.
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_mode_d = head_mode_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_data_d = ext_data;
          head_mode_d = in_mode;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept) begin
          head_data_d = ext_data;
          head_mode_d = in_mode;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    out_valid_d = (state_d != EMPTY);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_mode_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_mode_q <= head_mode_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_mode  = head_mode_q;

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate-extension unit for the KGP-RISC decode stage. It takes a raw instruction immediate field plus an extension mode and produces a full-width operand, registered, behind a valid/ready handshake. Four modes are supported: sign-extend, zero-extend, branch-offset (sign-extend then shift) and upper placement. An optional skid buffer lets the unit absorb a back-pressure cycle without a combinational ready path.

## Interface
- IN_W, 26, width of raw immediate input
- OUT_W, 32, width of extended output; must satisfy OUT_W >= IN_W + SHIFT and OUT_W >= 2*SHORT_W
- SHORT_W, 16, width of short immediate field (in_data[SHORT_W-1:0]) used by modes 0, 1, 3
- SHIFT, 2, left-shift amount applied in mode 2
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all buffered entries
- in_valid  input  1  in_data/in_mode valid
- in_ready  output  1  unit can accept this cycle
- in_data  input  IN_W  raw immediate
- in_mode  input  2  extension mode
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts this cycle
- out_data  output  OUT_W  extended result
- out_mode  output  2  mode echoed with the result

## Operation
- Accept on in_valid && in_ready; deliver on out_valid && out_ready.
- Extension is computed combinationally at the input and stored; outputs come only from registers.
- Mode 0: sign-extend in_data[SHORT_W-1:0] to OUT_W.
- Mode 1: zero-extend in_data[SHORT_W-1:0] to OUT_W.
- Mode 2: sign-extend full in_data[IN_W-1:0] to OUT_W, then shift left by SHIFT; bits shifted out above OUT_W are discarded.
- Mode 3: out_data = in_data[SHORT_W-1:0] placed in bits [OUT_W-1:OUT_W-SHORT_W], all lower bits zero.
- The storage is a 2-entry skid buffer with states EMPTY, ONE and FULL. The head entry drives out_*.
  - EMPTY --accept--> ONE.
  - ONE: accept and deliver in the same cycle stays ONE, with the head replaced. Accept without deliver --> FULL, with the new entry written to the skid slot. Deliver without accept --> EMPTY.
  - FULL: deliver moves the skid entry to the head --> ONE. No accept is possible in FULL.
- in_ready = (state != FULL). It is a registered decode of state with no combinational path from out_ready.
- Ordering is strictly FIFO, with no reordering or dropping.
- flush: the next state is EMPTY, and any input offered in the flush cycle is discarded. flush has priority over accept and deliver. An output handshake completing in the flush cycle still counts as delivered.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is valid on out_* after edge N.
- Throughput is 1 per cycle while out_ready stays high.
- Reset (async assert, rst_n low): state = EMPTY, out_valid = 0, out_data = 0, out_mode = 0, in_ready = 1 immediately after assert.
- Reset release is synchronous to clk. The first accept is possible at the first edge after rst_n rises.
- Reset mid-operation drops all buffered entries, with no partial outputs.
- out_data and out_mode are stable while out_valid && !out_ready.

## Configuration
- IMM_EXT_SKID_EN defined: 2-entry skid buffer as above; in_ready is registered.
- Undefined: single register stage with states EMPTY and ONE only.
  - in_ready = !out_valid || out_ready, which is combinational from out_ready.
  - Same latency, throughput, modes, flush and reset behaviour.

## Test plan
- Modes, no stall: in_data=26'h2D486D7 with modes 0,1,2,3 in consecutive cycles, out_ready=1 -> out_data = 32'hFFFF86D7, 32'h000086D7, 32'hFB521B5C, 32'h86D70000, each 1 cycle after accept.
- Positive operand: in_data=26'h180042B in modes 0 and 2 -> out_data = 32'h0000042B and 32'h060010AC.
- Back-pressure: hold out_ready=0 and offer 3 inputs back-to-back.
  - With IMM_EXT_SKID_EN: 2 are accepted, then in_ready=0.
  - Without it: 1 is accepted.
  - After release, outputs drain in order, one per cycle.
- Simultaneous events: in state ONE, accept and deliver in the same cycle -> state stays ONE, and the new result appears next cycle with no bubble.
- Flush: in FULL, assert flush together with in_valid=1 -> out_valid=0 next cycle, in_ready=1, offered input not delivered.
- Async reset: assert rst_n=0 between clock edges while FULL -> out_valid=0, out_data=0 and in_ready=1 with no clock edge; no stale output after release.
